sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Shares the single SDRAM controller burst port between NPORT FIFO-bridge requesters, e.g. audio record and playback channels. Each requester presents level write/read burst requests with address and length. The arbiter grants one burst at a time in round-robin order and muxes address, length and write data onto the controller port. It routes the controller's wr/rd acknowledge back to the granted requester only, and sits between the per-channel FIFO bridges and the SDRAM controller in the clk_ref domain.

## Interface
- NPORT, 2, number of requesters (2..4)
- ADDR_W, 22, SDRAM address width {bank,row,col}
- LEN_W, 9, burst length width
- TIMEOUT, 1023, ack watchdog limit in cycles (used only with SDRAM_ARB_TIMEOUT_EN)
- clk_ref  in  1  sole clock, SDRAM controller clock
- rst_n  in  1  asynchronous, active-low reset
- port_wr_req  in  NPORT  per-port write-burst request, level
- port_rd_req  in  NPORT  per-port read-burst request, level
- port_wraddr  in  NPORT*ADDR_W  per-port write address, port i at [i*ADDR_W +: ADDR_W]
- port_rdaddr  in  NPORT*ADDR_W  per-port read address
- port_wrlen  in  NPORT*LEN_W  per-port write burst length
- port_rdlen  in  NPORT*LEN_W  per-port read burst length
- port_din  in  NPORT*16  per-port write data
- port_wr_ack  out  NPORT  sdram_wr_ack routed to granted port, 0 elsewhere
- port_rd_ack  out  NPORT  sdram_rd_ack routed to granted port, 0 elsewhere
- sdram_wr_req  out  1  write request to controller
- sdram_rd_req  out  1  read request to controller
- sdram_wr_ack  in  1  controller write acknowledge, high for whole burst
- sdram_rd_ack  in  1  controller read acknowledge, high for whole burst
- sdram_wraddr  out  ADDR_W  registered write address of granted burst
- sdram_rdaddr  out  ADDR_W  registered read address of granted burst
- sdram_wr_length  out  LEN_W  registered write length
- sdram_rd_length  out  LEN_W  registered read length
- sdram_din  out  16  port_din of granted port, combinational mux; 0 when idle
- grant  out  NPORT  one-hot current owner, 0 when idle
- arb_err  out  1  sticky watchdog error (0 without macro)

## Operation
- States: IDLE, REQ, BURST, DONE.
- IDLE: scan ports starting at rr_ptr, wrapping modulo NPORT. Select the first port with wr or rd request pending. Latch its grant, op (write wins if both are pending), address and length. Go to REQ.
- REQ: assert sdram_wr_req or sdram_rd_req per latched op.
  - On the matching ack seen high: drop the req and go to BURST.
  - If the granted port drops its req before the ack: deassert, return to IDLE, rr_ptr unchanged.
- BURST: hold grant and ack routing. On the ack falling edge (prev 1, now 0), go to DONE.
- DONE: clear grant, set rr_ptr = granted+1 mod NPORT, go to IDLE.
- Fairness is by port, not by op. A port with both requests pending gets its write, then another port's request, then its read.
- An ack arriving for the non-selected op, or while in IDLE, is ignored and not routed.
- All outputs reset to 0. State resets to IDLE and rr_ptr to 0.
- Reset mid-burst forces all outputs to 0 immediately. Controller recovery is outside this block.
- No arithmetic on addresses; values pass through latched.

## Timing
- Request at IDLE to sdram_*_req high: 2 cycles (1 to decide and latch, then req registered).
- sdram_*_req low 1 cycle after ack first sampled high.
- port_*_ack = sdram_*_ack & grant bit, combinational, zero latency.
- Ack falling edge to next grant decision: 2 cycles (DONE, then IDLE).
- sdram_*addr and length are stable from req assertion until the DONE exit.

## Configuration
- SDRAM_ARB_TIMEOUT_EN defined:
  - A counter runs in REQ. If it reaches TIMEOUT with no ack: drop the req, set arb_err, clear the grant, advance rr_ptr, go to IDLE.
  - arb_err clears only on reset.
- Not defined: REQ waits indefinitely, and arb_err is tied to 0.

## Structure
- Package sdram_arb_pkg: state encoding constants (IDLE/REQ/BURST/DONE), default ADDR_W/LEN_W values.
- Sub-module rr_pick: combinational round-robin first-set search, taking the request vector and rr_ptr and producing a one-hot select plus a valid flag.

## Test plan
- Port0 wr_req only, addr 0x000100, len 256. Response: sdram_wr_req 2 cycles later, wraddr 0x000100, wr_length 256. port_wr_ack[0] mirrors ack and port_wr_ack[1] stays 0.
- Both ports wr_req continuously, four bursts: grants alternate 0,1,0,1.
- Port1 wr and rd both pending, port0 rd pending, rr_ptr=1. Order: port1 write, port0 read, port1 read.
- Port0 drops wr_req while in REQ. Response: sdram_wr_req low the next cycle, grant 0, and the next grant still starts scanning at port0.
- rst_n low during BURST. Response: all outputs 0 the same cycle; after release, the first grant goes to port0.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT=15, never ack. Response: req drops after 15 cycles, arb_err=1 sticky, and the other port is granted next.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared definitions for the SDRAM burst-port arbiter.
//               Contains the FSM state encoding, default address and length
//               widths, and a helper that sizes the round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_BURST = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Default widths: address is {bank,row,col}
    localparam int c_ADDR_W_DEF = 22;
    localparam int c_LEN_W_DEF  = 9;
    localparam int c_DATA_W     = 16;

    // Width of a pointer that indexes n ports (at least one bit)
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin first-set search. Starting at
//               i_ptr and wrapping modulo NPORT, selects the first port whose
//               request bit is set.
// Ports       : i_req   - per-port request vector
//               i_ptr   - index of the highest-priority port
//               o_sel   - one-hot selected port (0 when none)
//               o_valid - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NPORT = 2,
    parameter int PTR_W = ptr_width(NPORT)
) (
    input  logic [NPORT-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NPORT-1:0] o_sel,
    output logic             o_valid
);

    logic w_found;

    // Outer loop walks the rotation distance from i_ptr; the inner loop finds
    // the port sitting at that distance. The first hit wins.
    always_comb begin
        o_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (!w_found && i_req[i] &&
                    (((i + NPORT - int'(i_ptr)) % NPORT) == k)) begin
                    o_sel[i] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Shares one SDRAM controller burst port between NPORT
//               FIFO-bridge requesters. One burst is granted at a time in
//               round-robin order (fairness by port). Address/length are
//               latched at grant time; write data is muxed combinationally.
//               Controller acks are routed only to the granted port and only
//               for the granted operation.
// Ports       : clk_ref, rst_n (async, active low)
//               port_wr_req/port_rd_req    - per-port level burst requests
//               port_wraddr/port_rdaddr    - per-port addresses
//               port_wrlen/port_rdlen      - per-port burst lengths
//               port_din                   - per-port write data
//               port_wr_ack/port_rd_ack    - routed controller acks
//               sdram_wr_req/sdram_rd_req  - requests to controller
//               sdram_wr_ack/sdram_rd_ack  - controller acks (burst-long)
//               sdram_wraddr/sdram_rdaddr  - latched addresses
//               sdram_wr_length/sdram_rd_length - latched lengths
//               sdram_din                  - write data of granted port
//               grant                      - one-hot current owner
//               arb_err                    - sticky watchdog error
// Config      : SDRAM_ARB_TIMEOUT_EN - enables the REQ-state ack watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORT   = 2,
    parameter int ADDR_W  = c_ADDR_W_DEF,
    parameter int LEN_W   = c_LEN_W_DEF,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk_ref,
    input  logic                       rst_n,
    input  logic [NPORT-1:0]           port_wr_req,
    input  logic [NPORT-1:0]           port_rd_req,
    input  logic [NPORT*ADDR_W-1:0]    port_wraddr,
    input  logic [NPORT*ADDR_W-1:0]    port_rdaddr,
    input  logic [NPORT*LEN_W-1:0]     port_wrlen,
    input  logic [NPORT*LEN_W-1:0]     port_rdlen,
    input  logic [NPORT*c_DATA_W-1:0]  port_din,
    output logic [NPORT-1:0]           port_wr_ack,
    output logic [NPORT-1:0]           port_rd_ack,
    output logic                       sdram_wr_req,
    output logic                       sdram_rd_req,
    input  logic                       sdram_wr_ack,
    input  logic                       sdram_rd_ack,
    output logic [ADDR_W-1:0]          sdram_wraddr,
    output logic [ADDR_W-1:0]          sdram_rdaddr,
    output logic [LEN_W-1:0]           sdram_wr_length,
    output logic [LEN_W-1:0]           sdram_rd_length,
    output logic [c_DATA_W-1:0]        sdram_din,
    output logic [NPORT-1:0]           grant,
    output logic                       arb_err
);

    localparam int c_PTR_W = ptr_width(NPORT);

    // ------------------------------------------------------------------------
    // State and datapath registers with their next values
    // ------------------------------------------------------------------------
    logic [1:0]          r_state,    w_state_nxt;
    logic [NPORT-1:0]    r_grant,    w_grant_nxt;
    logic                r_op_wr,    w_op_wr_nxt;
    logic                r_wr_req,   w_wr_req_nxt;
    logic                r_rd_req,   w_rd_req_nxt;
    logic                r_ack_prev;
    logic [c_PTR_W-1:0]  r_rr_ptr,   w_rr_ptr_nxt;
    logic [ADDR_W-1:0]   r_wraddr,   w_wraddr_nxt;
    logic [ADDR_W-1:0]   r_rdaddr,   w_rdaddr_nxt;
    logic [LEN_W-1:0]    r_wrlen,    w_wrlen_nxt;
    logic [LEN_W-1:0]    r_rdlen,    w_rdlen_nxt;

    logic [NPORT-1:0]    w_sel;
    logic                w_pick_valid;
    logic [ADDR_W-1:0]   w_sel_wraddr, w_sel_rdaddr;
    logic [LEN_W-1:0]    w_sel_wrlen,  w_sel_rdlen;
    logic [c_PTR_W-1:0]  w_gnt_idx,    w_ptr_adv;
    logic [c_DATA_W-1:0] w_din;
    logic                w_ack;
    logic                w_own_req;
    logic                w_tmo_take;

    // ------------------------------------------------------------------------
    // Round-robin selection over ports with any request pending
    // ------------------------------------------------------------------------
    rr_pick #(
        .NPORT (NPORT),
        .PTR_W (c_PTR_W)
    ) u_rr_pick (
        .i_req   (port_wr_req | port_rd_req),
        .i_ptr   (r_rr_ptr),
        .o_sel   (w_sel),
        .o_valid (w_pick_valid)
    );

    // Address/length of the port the picker is pointing at
    always_comb begin
        w_sel_wraddr = '0;
        w_sel_rdaddr = '0;
        w_sel_wrlen  = '0;
        w_sel_rdlen  = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (w_sel[i]) begin
                w_sel_wraddr = port_wraddr[i*ADDR_W +: ADDR_W];
                w_sel_rdaddr = port_rdaddr[i*ADDR_W +: ADDR_W];
                w_sel_wrlen  = port_wrlen[i*LEN_W +: LEN_W];
                w_sel_rdlen  = port_rdlen[i*LEN_W +: LEN_W];
            end
        end
    end

    // Index and write data of the current owner; zero while idle
    always_comb begin
        w_gnt_idx = '0;
        w_din     = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (r_grant[i]) begin
                w_gnt_idx = c_PTR_W'(i);
                w_din     = port_din[i*c_DATA_W +: c_DATA_W];
            end
        end
    end

    assign w_ptr_adv = (w_gnt_idx == c_PTR_W'(NPORT-1)) ? '0
                                                        : w_gnt_idx + c_PTR_W'(1);

    // Ack and request of the latched operation only; the other op is ignored
    assign w_ack     = r_op_wr ? sdram_wr_ack : sdram_rd_ack;
    assign w_own_req = r_op_wr ? |(port_wr_req & r_grant)
                               : |(port_rd_req & r_grant);

    // ------------------------------------------------------------------------
    // Optional ack watchdog: counts cycles with the request asserted
    // ------------------------------------------------------------------------
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_err;

    assign w_tmo_take = (r_state == c_ST_REQ) && (r_wr_req || r_rd_req) &&
                        !w_ack && w_own_req &&
                        (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state != c_ST_REQ) begin
                r_tmo_cnt <= '0;
            end else if (r_wr_req || r_rd_req) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
            if (w_tmo_take) begin
                r_err <= 1'b1;
            end
        end
    end

    assign arb_err = r_err;
`else
    assign w_tmo_take = 1'b0;
    assign arb_err    = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_op_wr_nxt  = r_op_wr;
        w_wr_req_nxt = r_wr_req;
        w_rd_req_nxt = r_rd_req;
        w_rr_ptr_nxt = r_rr_ptr;
        w_wraddr_nxt = r_wraddr;
        w_rdaddr_nxt = r_rdaddr;
        w_wrlen_nxt  = r_wrlen;
        w_rdlen_nxt  = r_rdlen;

        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt  = w_sel;
                    // Write wins when a port has both requests pending
                    w_op_wr_nxt  = |(port_wr_req & w_sel);
                    w_wraddr_nxt = w_sel_wraddr;
                    w_rdaddr_nxt = w_sel_rdaddr;
                    w_wrlen_nxt  = w_sel_wrlen;
                    w_rdlen_nxt  = w_sel_rdlen;
                    w_state_nxt  = c_ST_REQ;
                end
            end

            c_ST_REQ: begin
                if (w_ack) begin
                    w_wr_req_nxt = 1'b0;
                    w_rd_req_nxt = 1'b0;
                    w_state_nxt  = c_ST_BURST;
                end else if (!w_own_req) begin
                    // Requester withdrew: give up without moving the pointer
                    w_wr_req_nxt = 1'b0;
                    w_rd_req_nxt = 1'b0;
                    w_grant_nxt  = '0;
                    w_state_nxt  = c_ST_IDLE;
                end else if (w_tmo_take) begin
                    w_wr_req_nxt = 1'b0;
                    w_rd_req_nxt = 1'b0;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = w_ptr_adv;
                    w_state_nxt  = c_ST_IDLE;
                end else begin
                    w_wr_req_nxt = r_op_wr;
                    w_rd_req_nxt = ~r_op_wr;
                end
            end

            c_ST_BURST: begin
                // Burst ends on the falling edge of the owning ack
                if (r_ack_prev && !w_ack) begin
                    w_state_nxt = c_ST_DONE;
                end
            end

            default: begin  // c_ST_DONE
                w_grant_nxt  = '0;
                w_rr_ptr_nxt = w_ptr_adv;
                w_state_nxt  = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_grant    <= '0;
            r_op_wr    <= 1'b0;
            r_wr_req   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_ack_prev <= 1'b0;
            r_rr_ptr   <= '0;
            r_wraddr   <= '0;
            r_rdaddr   <= '0;
            r_wrlen    <= '0;
            r_rdlen    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_op_wr    <= w_op_wr_nxt;
            r_wr_req   <= w_wr_req_nxt;
            r_rd_req   <= w_rd_req_nxt;
            r_ack_prev <= w_ack;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_wraddr   <= w_wraddr_nxt;
            r_rdaddr   <= w_rdaddr_nxt;
            r_wrlen    <= w_wrlen_nxt;
            r_rdlen    <= w_rdlen_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign grant           = r_grant;
    assign sdram_wr_req    = r_wr_req;
    assign sdram_rd_req    = r_rd_req;
    assign sdram_wraddr    = r_wraddr;
    assign sdram_rdaddr    = r_rdaddr;
    assign sdram_wr_length = r_wrlen;
    assign sdram_rd_length = r_rdlen;
    assign sdram_din       = w_din;
    assign port_wr_ack     = r_grant & {NPORT{sdram_wr_ack &  r_op_wr}};
    assign port_rd_ack     = r_grant & {NPORT{sdram_rd_ack & ~r_op_wr}};

endmodule
`default_nettype wire
